// File: rtl/if_id_fetch_stage_if.sv
// Bundle between the fetch stage and its neighbours (IM, hazard/branch unit, decode).
// The stage side uses the master modport; the environment/bench uses the slave modport.
interface if_id_fetch_stage_if #(
  parameter int ADDR_W = 32
);
  // Control requests from hazard/branch logic.
  logic              stall_i;
  logic              branch_taken_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              flush_i;
  // Instruction memory (combinational read at pc_o).
  logic [31:0]       instr_i;
  logic [ADDR_W-1:0] pc_o;
  // Handshake: decode consumes if_id_instr_o/if_id_pc4_o only while
  // if_id_valid_o=1; there is no ready, back-pressure is expressed via stall_i.
  logic [31:0]       if_id_instr_o;
  logic [ADDR_W-1:0] if_id_pc4_o;
  logic              if_id_valid_o;
  logic              halted_o;
  logic [31:0]       fetch_cnt_o;
  logic [31:0]       stall_cnt_o;
  // Halt FSM state for observation: 0=RUN, 1=DRAIN, 2=HALT.
  logic [1:0]        dbg_state;

  modport master (
    input  stall_i, branch_taken_i, branch_target_i, flush_i, instr_i,
    output pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, halted_o,
           fetch_cnt_o, stall_cnt_o, dbg_state
  );

  modport slave (
    output stall_i, branch_taken_i, branch_target_i, flush_i, instr_i,
    input  pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, halted_o,
           fetch_cnt_o, stall_cnt_o, dbg_state
  );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register and end-of-program halt FSM.
// Optional macro FETCH_STATS_EN builds fetch/stall statistic counters.
module if_id_fetch_stage #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] PC_RESET    = '0,
  parameter int                DRAIN_DEPTH = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  if_id_fetch_stage_if.master  bus
);

  localparam int CNT_W = $clog2(DRAIN_DEPTH + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  zcnt_q, zcnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target_aligned;
  logic [CNT_W-1:0]  zcnt_inc;
  logic              advance;

  // Modulo 2^ADDR_W wrap is intended; the carry out is simply dropped.
  assign pc_plus4       = pc_q + ADDR_W'(4);
  assign target_aligned = bus.branch_target_i & ~ADDR_W'(3);
  assign zcnt_inc       = zcnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      zcnt_q  <= '0;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      zcnt_q  <= zcnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    zcnt_d  = zcnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    advance = 1'b0;

    if (state_q == HALT) begin
      // Frozen until reset; IF/ID decays to a bubble.
      instr_d = '0;
      valid_d = 1'b0;
    end else if (bus.branch_taken_i) begin
      pc_d    = target_aligned;
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
      state_d = RUN;
      zcnt_d  = '0;
    end else if (bus.flush_i) begin
      pc_d    = pc_plus4;
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (!bus.stall_i) begin
      advance = 1'b1;
      pc_d    = pc_plus4;
      instr_d = bus.instr_i;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      // Zero words still enter IF/ID as no-ops while the run is counted.
      if (bus.instr_i == 32'd0) begin
        zcnt_d = zcnt_inc;
        if (zcnt_inc >= CNT_W'(DRAIN_DEPTH)) begin
          state_d = HALT;
        end else begin
          state_d = DRAIN;
        end
      end else begin
        state_d = RUN;
        zcnt_d  = '0;
      end
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.if_id_instr_o = instr_q;
  assign bus.if_id_pc4_o   = pc4_q;
  assign bus.if_id_valid_o = valid_q;
  assign bus.halted_o      = (state_q == HALT);
  assign bus.dbg_state     = state_q;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (state_q != HALT) begin
      if (advance) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (bus.stall_i && !bus.branch_taken_i) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.fetch_cnt_o = fetch_cnt_q;
  assign bus.stall_cnt_o = stall_cnt_q;
`else
  logic unused_advance;
  assign unused_advance  = advance;
  assign bus.fetch_cnt_o = '0;
  assign bus.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: halt detection, stall, branch, flush, wrap, async reset.
module tb_if_id_fetch_stage;
  localparam int ADDR_W = 32;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  if_id_fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();

  if_id_fetch_stage #(
    .ADDR_W(ADDR_W), .PC_RESET('0), .DRAIN_DEPTH(5)
  ) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory model: words 0/1 hold the program, everything else is zero
  // except a marker word at the top of the address space.
  function automatic logic [31:0] im_word(input logic [31:0] addr);
    if (addr == 32'h0000_0000) return 32'h2001_0005;
    if (addr == 32'h0000_0004) return 32'h2002_0007;
    if (addr == 32'hFFFF_FFFC) return 32'h0000_0013;
    return 32'h0;
  endfunction

  always_comb bus.instr_i = im_word(bus.pc_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input logic st, input logic br, input logic [31:0] tgt, input logic fl);
    bus.stall_i         = st;
    bus.branch_taken_i  = br;
    bus.branch_target_i = tgt;
    bus.flush_i         = fl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("rst_pc", bus.pc_o, 32'h0);
    chk("rst_instr", bus.if_id_instr_o, 32'h0);
    chk("rst_pc4", bus.if_id_pc4_o, 32'h0);
    chk("rst_valid", 32'(bus.if_id_valid_o), 32'h0);
    chk("rst_halted", 32'(bus.halted_o), 32'h0);
    chk("rst_state", 32'(bus.dbg_state), 32'h0);
    chk("rst_fetch_cnt", bus.fetch_cnt_o, 32'h0);
    chk("rst_stall_cnt", bus.stall_cnt_o, 32'h0);
    #2 rst_n = 1'b1;

    // Program run: two real words then zeros; halt on edge 7.
    step();
    chk("e1_pc", bus.pc_o, 32'h4);
    chk("e1_instr", bus.if_id_instr_o, 32'h2001_0005);
    chk("e1_pc4", bus.if_id_pc4_o, 32'h4);
    chk("e1_valid", 32'(bus.if_id_valid_o), 32'h1);
    step();
    chk("e2_pc", bus.pc_o, 32'h8);
    chk("e2_instr", bus.if_id_instr_o, 32'h2002_0007);
    step();
    chk("e3_state_drain", 32'(bus.dbg_state), 32'h1);
    chk("e3_valid_zero_word", 32'(bus.if_id_valid_o), 32'h1);
    step(); step(); step();
    chk("e6_not_halted", 32'(bus.halted_o), 32'h0);
    chk("e6_pc", bus.pc_o, 32'h18);
    step();
    chk("e7_halted", 32'(bus.halted_o), 32'h1);
    chk("e7_pc", bus.pc_o, 32'h1C);
    chk("e7_state", 32'(bus.dbg_state), 32'h2);
    set_in(1'b0, 1'b1, 32'h40, 1'b0);
    step();
    chk("halt_pc_frozen", bus.pc_o, 32'h1C);
    chk("halt_valid", 32'(bus.if_id_valid_o), 32'h0);
    chk("halt_sticky", 32'(bus.halted_o), 32'h1);
    set_in(1'b0, 1'b0, 32'h0, 1'b0);

    // Asynchronous reset in the middle of a cycle while halted.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_halted", 32'(bus.halted_o), 32'h0);
    chk("async_rst_pc", bus.pc_o, 32'h0);
    chk("async_rst_state", 32'(bus.dbg_state), 32'h0);
    #1 rst_n = 1'b1;

    // Stall for two edges at pc=8.
    step(); step();
    chk("pre_stall_pc", bus.pc_o, 32'h8);
    set_in(1'b1, 1'b0, 32'h0, 1'b0);
    step();
    chk("stall1_pc", bus.pc_o, 32'h8);
    chk("stall1_instr", bus.if_id_instr_o, 32'h2002_0007);
    step();
    chk("stall2_pc", bus.pc_o, 32'h8);
    chk("stall2_pc4", bus.if_id_pc4_o, 32'h8);
    chk("stall2_valid", 32'(bus.if_id_valid_o), 32'h1);
    chk("stall_cnt_off", bus.stall_cnt_o, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk("resume_pc", bus.pc_o, 32'hC);
    chk("resume_pc4", bus.if_id_pc4_o, 32'hC);
    step();
    chk("pre_branch_pc", bus.pc_o, 32'h10);
    chk("pre_branch_state", 32'(bus.dbg_state), 32'h1);

    // Branch wins over stall; target low bits cleared; DRAIN -> RUN.
    set_in(1'b1, 1'b1, 32'h23, 1'b0);
    step();
    chk("br_pc", bus.pc_o, 32'h20);
    chk("br_valid", 32'(bus.if_id_valid_o), 32'h0);
    chk("br_instr", bus.if_id_instr_o, 32'h0);
    chk("br_pc4", bus.if_id_pc4_o, 32'h0);
    chk("br_state_run", 32'(bus.dbg_state), 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b0);

    // Reach DRAIN with count 3, then branch to 0 (nonzero word) restarts the run.
    step(); step(); step();
    chk("drain3_pc", bus.pc_o, 32'h2C);
    chk("drain3_state", 32'(bus.dbg_state), 32'h1);
    set_in(1'b0, 1'b1, 32'h0, 1'b0);
    step();
    chk("br0_pc", bus.pc_o, 32'h0);
    chk("br0_state_run", 32'(bus.dbg_state), 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    step(); step();
    step();
    chk("z1_state", 32'(bus.dbg_state), 32'h1);
    // Flush during a zero fetch: bubble, PC advances, zero count unchanged.
    set_in(1'b0, 1'b0, 32'h0, 1'b1);
    step();
    chk("flush_pc", bus.pc_o, 32'h10);
    chk("flush_valid", 32'(bus.if_id_valid_o), 32'h0);
    chk("flush_instr", bus.if_id_instr_o, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    step(); step(); step();
    chk("z4_not_halted", 32'(bus.halted_o), 32'h0);
    step();
    chk("z5_halted", 32'(bus.halted_o), 32'h1);
    chk("z5_pc", bus.pc_o, 32'h20);

    // PC wrap at the top of the address space.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    set_in(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step();
    chk("wrap_pre_pc", bus.pc_o, 32'hFFFF_FFFC);
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk("wrap_pc", bus.pc_o, 32'h0);
    chk("wrap_pc4", bus.if_id_pc4_o, 32'h0);
    chk("wrap_instr", bus.if_id_instr_o, 32'h0000_0013);
    chk("wrap_valid", 32'(bus.if_id_valid_o), 32'h1);
    chk("fetch_cnt_off", bus.fetch_cnt_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage Pipeline_CPU. Owns the PC register and the IF/ID pipeline register.
- Drives the instruction-memory address and accepts the combinational instruction word back in the same cycle.
- Applies stall, branch-redirect and flush requests from the downstream hazard and branch logic.
- Detects end-of-program: a run of all-zero instruction words. On detection it drains the pipeline and raises a sticky halt flag.

Parameters:
- ADDR_W, 32, PC and address width.
- PC_RESET, 0, PC value loaded on reset.
- DRAIN_DEPTH, 5, consecutive zero-word fetches needed before HALT (pipeline depth).

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall_i  in  1  load-use stall from the hazard unit; hold PC and IF/ID.
- branch_taken_i  in  1  redirect request; the resolved branch is taken.
- branch_target_i  in  ADDR_W  redirect target address.
- flush_i  in  1  insert a bubble in IF/ID without changing PC redirect.
- instr_i  in  32  instruction word read from IM at pc_o.
- pc_o  out  ADDR_W  current fetch address to IM (registered PC value).
- if_id_instr_o  out  32  IF/ID instruction; 0 when a bubble.
- if_id_pc4_o  out  ADDR_W  IF/ID copy of PC+4.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- halted_o  out  1  sticky end-of-program flag.
- fetch_cnt_o  out  32  instructions fetched (optional feature).
- stall_cnt_o  out  32  stall cycles (optional feature).

Behaviour:
- Reset (async, rst_n=0), all outputs and state forced immediately:
  - pc = PC_RESET; if_id_instr_o = 0; if_id_pc4_o = 0; if_id_valid_o = 0; halted_o = 0.
  - FSM = RUN; zero counter = 0; stat counters = 0.
- Deassertion of reset takes effect at the next rising edge.
- pc_o is the PC register output directly. IM is asynchronous, so instr_i belongs to pc_o in the same cycle. Fetch latency to IF/ID is 1 cycle.
- Priority per rising edge, highest first:
  - HALT state: everything frozen. PC holds. IF/ID is held as a bubble (instr 0, valid 0). All inputs are ignored.
  - branch_taken_i: pc <= {branch_target_i[ADDR_W-1:2], 2'b00}; IF/ID <= bubble (instr 0, pc4 0, valid 0). Wins over stall_i and flush_i in the same cycle.
  - flush_i (no branch): IF/ID <= bubble; pc <= pc+4 (the fetched word is discarded).
  - stall_i: pc, IF/ID, FSM and zero counter all hold.
  - normal: pc <= pc+4; if_id_instr_o <= instr_i; if_id_pc4_o <= pc+4; if_id_valid_o <= 1.
- PC arithmetic is modulo 2^ADDR_W: 0xFFFFFFFC + 4 = 0x00000000, with no error.
- Halt FSM states: RUN, DRAIN, HALT.
  - Zero counter counts only on normal advance cycles. Stalls and flushes leave it unchanged.
  - RUN -> DRAIN: a normal advance with instr_i == 0. Zero counter = 1.
  - DRAIN, normal advance with instr_i == 0: counter++. When counter reaches DRAIN_DEPTH, go to HALT and set halted_o = 1 at that edge.
  - DRAIN, normal advance with instr_i != 0: back to RUN, counter = 0.
  - DRAIN, branch_taken_i: back to RUN, counter = 0.
  - HALT: exits only by reset. halted_o stays 1.
- The zero words fetched during DRAIN still enter IF/ID with valid 1. Downstream treats them as no-ops.
- DRAIN_DEPTH = 1: the first zero fetch goes straight to HALT at that edge.
- Reset mid-DRAIN or in HALT: immediate return to the reset state.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - fetch_cnt_o increments on each normal advance.
  - stall_cnt_o increments on each cycle where stall_i=1 and branch_taken_i=0, outside HALT.
  - Both are 32-bit, wrap at 2^32, and freeze in HALT.
- Not defined: the ports still exist and are tied to 0, and no counter flops are built.

Test Plan:
- Reset, then IM = 0x20010005, 0x20020007 followed by zeros -> pc_o = 0, 4, 8, … per cycle. if_id_instr_o = 0x20010005 after edge 1, 0x20020007 after edge 2. halted_o = 1 exactly at edge 7: 2 real fetches plus 5 zero fetches.
- stall_i=1 for 2 cycles at pc=8 -> pc_o stays 8 and IF/ID is unchanged for 2 edges, then resumes at 12. With FETCH_STATS_EN, stall_cnt_o = 2.
- branch_taken_i=1 with target 0x23 while stall_i=1 at pc=0x10 -> pc_o = 0x20 and if_id_valid_o = 0 after the edge, with no stall hold.
- In DRAIN with counter = 3, branch_taken_i=1 with target 0x0, IM[0] nonzero -> FSM returns to RUN. halted_o needs a fresh 5 zero fetches before asserting.
- pc = 0xFFFFFFFC with a normal advance -> pc_o = 0x00000000 and if_id_pc4_o = 0x00000000.
- rst_n dropped asynchronously mid-cycle while in HALT -> halted_o = 0 and pc_o = 0 immediately, without waiting for a clock edge.
